// File: rtl/dmi_reg_responder.sv
// dmi_reg_responder: target end of a DMI request/response link backed by a
// local 32-bit register file, with a fixed, parameterised response latency.
// Optional build macro DMI_REG_RESPONDER_STATS_EN maps a read-only saturating
// count of accepted requests at address 7'h7F.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request; op executes on the accept edge
// ST_WAIT   | latency countdown, request channel closed
// ST_RESP   | response presented, held until dmi_rsp_ready
module dmi_reg_responder #(
    parameter int unsigned NumRegs    = 16,
    parameter int unsigned RspLatency = 2,
    parameter logic [31:0] ResetVal   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic [6:0]  dmi_req_addr,
    input  logic [1:0]  dmi_req_op,
    input  logic [31:0] dmi_req_data,
    output logic        dmi_rsp_valid,
    input  logic        dmi_rsp_ready,
    output logic [31:0] dmi_rsp_data,
    output logic [1:0]  dmi_rsp_resp,
    input  logic        dmi_rst_n
);

    localparam int unsigned IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [7:0]  NumRegsL = 8'(NumRegs);
    localparam logic [7:0]  LatL     = 8'(RspLatency);
    localparam logic [1:0]  OpNop    = 2'd0;
    localparam logic [1:0]  OpRead   = 2'd1;
    localparam logic [1:0]  OpWrite  = 2'd2;
    localparam logic [1:0]  RespOk   = 2'd0;
    localparam logic [1:0]  RespFail = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] regs_q [NumRegs];
    logic [31:0] regs_d [NumRegs];
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic        init_done_q, init_done_d;
    logic        accept;
    logic        in_range;
    logic [IdxW-1:0] idx;

`ifdef DMI_REG_RESPONDER_STATS_EN
    localparam logic [6:0] StatAddr = 7'h7F;
    logic [31:0] stat_q, stat_d, stat_inc;
`endif

    assign dmi_req_ready = (state_q == ST_IDLE) && init_done_q && dmi_rst_n;
    assign dmi_rsp_valid = (state_q == ST_RESP);
    assign dmi_rsp_data  = rsp_data_q;
    assign dmi_rsp_resp  = rsp_resp_q;
    assign accept        = dmi_req_valid && dmi_req_ready;
    assign in_range      = ({1'b0, dmi_req_addr} < NumRegsL);
    assign idx           = dmi_req_addr[IdxW-1:0];

    // Next-state, register-file update and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        init_done_d = 1'b1;
`ifdef DMI_REG_RESPONDER_STATS_EN
        stat_inc = (&stat_q) ? stat_q : stat_q + 32'd1;
        stat_d   = stat_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef DMI_REG_RESPONDER_STATS_EN
                    stat_d = stat_inc;
`endif
                    rsp_data_d = 32'h0;
                    rsp_resp_d = RespFail;
                    case (dmi_req_op)
                        OpNop: rsp_resp_d = RespOk;
                        OpRead: begin
                            if (in_range) begin
                                rsp_data_d = regs_q[idx];
                                rsp_resp_d = RespOk;
                            end
`ifdef DMI_REG_RESPONDER_STATS_EN
                            else if (dmi_req_addr == StatAddr) begin
                                rsp_data_d = stat_inc;
                                rsp_resp_d = RespOk;
                            end
`endif
                        end
                        OpWrite: begin
                            if (in_range) begin
                                regs_d[idx] = dmi_req_data;
                                rsp_resp_d  = RespOk;
                            end
                        end
                        default: rsp_resp_d = RespFail;
                    endcase
                    cnt_d   = LatL;
                    state_d = (LatL == 8'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (dmi_rsp_ready) begin
                    state_d    = ST_IDLE;
                    rsp_data_d = 32'h0;
                    rsp_resp_d = RespOk;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Functional reset from the initiator wins over everything, including a pending response.
        if (!dmi_rst_n) begin
            state_d    = ST_IDLE;
            cnt_d      = 8'd0;
            regs_d     = '{default: ResetVal};
            rsp_data_d = 32'h0;
            rsp_resp_d = RespOk;
`ifdef DMI_REG_RESPONDER_STATS_EN
            stat_d     = 32'h0;
`endif
        end
    end

    // State, counter, register file and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            regs_q      <= '{default: ResetVal};
            rsp_data_q  <= 32'h0;
            rsp_resp_q  <= RespOk;
            init_done_q <= 1'b0;
`ifdef DMI_REG_RESPONDER_STATS_EN
            stat_q      <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            init_done_q <= init_done_d;
`ifdef DMI_REG_RESPONDER_STATS_EN
            stat_q      <= stat_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Scoreboard bench for dmi_reg_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them and checks response latency.
module tb_dmi_reg_responder;

    localparam int Lat = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dmi_req_valid = 1'b0;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr = 7'd0;
    logic [1:0]  dmi_req_op = 2'd0;
    logic [31:0] dmi_req_data = 32'h0;
    logic        dmi_rsp_valid;
    logic        dmi_rsp_ready = 1'b1;
    logic [31:0] dmi_rsp_data;
    logic [1:0]  dmi_rsp_resp;
    logic        dmi_rst_n = 1'b1;

    dmi_reg_responder #(
        .NumRegs   (16),
        .RspLatency(Lat),
        .ResetVal  (32'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dmi_req_valid(dmi_req_valid),
        .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr (dmi_req_addr),
        .dmi_req_op   (dmi_req_op),
        .dmi_req_data (dmi_req_data),
        .dmi_rsp_valid(dmi_rsp_valid),
        .dmi_rsp_ready(dmi_rsp_ready),
        .dmi_rsp_data (dmi_rsp_data),
        .dmi_rsp_resp (dmi_rsp_resp),
        .dmi_rst_n    (dmi_rst_n)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   waiting = 1'b0;
    int   edge_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: latency from accept edge to first rsp_valid, and scoreboard compare on handshake.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (!dmi_rst_n) begin
                waiting = 1'b0;
            end else if (waiting) begin
                edge_cnt++;
                if (dmi_rsp_valid) begin
                    chk("rsp_latency", 32'(edge_cnt), 32'(Lat + 1));
                    waiting = 1'b0;
                end else if (edge_cnt > Lat + 8) begin
                    chk("rsp_latency_timeout", 32'(edge_cnt), 32'(Lat + 1));
                    waiting = 1'b0;
                end
            end
            if (dmi_req_valid && dmi_req_ready) begin
                waiting  = 1'b1;
                edge_cnt = 0;
            end
            if (dmi_rsp_valid && dmi_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_queue_depth", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", dmi_rsp_data, mon_e.data);
                    chk("rsp_resp", 32'(dmi_rsp_resp), 32'(mon_e.resp));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                         input bit push, input logic [31:0] edata, input logic [1:0] eresp);
        int guard = 0;
        exp_t e;
        @(posedge clk_i); #1;
        dmi_req_valid = 1'b1;
        dmi_req_op    = op;
        dmi_req_addr  = addr;
        dmi_req_data  = data;
        if (push) begin
            e.data = edata;
            e.resp = eresp;
            exp_q.push_back(e);
        end
        @(negedge clk_i);
        while (!dmi_req_ready && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (!dmi_req_ready) chk("accept_timeout", 32'(dmi_req_ready), 32'd1);
        @(posedge clk_i); #1;
        dmi_req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        @(negedge clk_i);
        while ((exp_q.size() != 0 || !dmi_req_ready) && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                        input logic [31:0] edata, input logic [1:0] eresp);
        issue(op, addr, data, 1'b1, edata, eresp);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        // Reset: all outputs low while rst_i is asserted, ready one edge after release
        repeat (2) @(negedge clk_i);
        chk("rst_req_ready", 32'(dmi_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(dmi_rsp_valid), 32'd0);
        chk("rst_rsp_data", dmi_rsp_data, 32'h0);
        chk("rst_rsp_resp", 32'(dmi_rsp_resp), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_before_first_edge", 32'(dmi_req_ready), 32'd0);
        @(negedge clk_i);
        chk("ready_after_first_edge", 32'(dmi_req_ready), 32'd1);

        // Write then read back
        xact(2'd2, 7'd3, 32'hDEADBEEF, 32'h0, 2'd0);
        xact(2'd1, 7'd3, 32'h0, 32'hDEADBEEF, 2'd0);

        // Failures leave registers untouched; address boundary 15/16
        xact(2'd1, 7'd20, 32'h0, 32'h0, 2'd2);
        xact(2'd3, 7'd0, 32'h12345678, 32'h0, 2'd2);
        xact(2'd1, 7'd0, 32'h0, 32'h0, 2'd0);
        xact(2'd1, 7'd3, 32'h0, 32'hDEADBEEF, 2'd0);
        xact(2'd2, 7'd15, 32'hCAFEF00D, 32'h0, 2'd0);
        xact(2'd1, 7'd15, 32'h0, 32'hCAFEF00D, 2'd0);
        xact(2'd2, 7'd16, 32'h55555555, 32'h0, 2'd2);
        xact(2'd1, 7'd16, 32'h0, 32'h0, 2'd2);
        xact(2'd0, 7'd9, 32'hFFFFFFFF, 32'h0, 2'd0);

        // Backpressure: response held stable, request channel closed
        dmi_rsp_ready = 1'b0;
        issue(2'd1, 7'd3, 32'h0, 1'b1, 32'hDEADBEEF, 2'd0);
        guard = 0;
        @(negedge clk_i);
        while (!dmi_rsp_valid && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(dmi_rsp_valid), 32'd1);
            chk("bp_rsp_data", dmi_rsp_data, 32'hDEADBEEF);
            chk("bp_rsp_resp", 32'(dmi_rsp_resp), 32'd0);
            chk("bp_req_ready", 32'(dmi_req_ready), 32'd0);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        dmi_rsp_ready = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("bp_ready_after_handshake", 32'(dmi_req_ready), 32'd1);
        chk("bp_valid_after_handshake", 32'(dmi_rsp_valid), 32'd0);
        drain();
        xact(2'd1, 7'd15, 32'h0, 32'hCAFEF00D, 2'd0);

        // Functional reset during WAIT drops the response and clears registers
        issue(2'd2, 7'd5, 32'h1, 1'b0, 32'h0, 2'd0);
        dmi_rst_n     = 1'b0;
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd1;
        dmi_req_addr  = 7'd5;
        @(negedge clk_i);
        chk("frst_req_ready_low", 32'(dmi_req_ready), 32'd0);
        @(negedge clk_i);
        chk("frst_req_ready_low2", 32'(dmi_req_ready), 32'd0);
        chk("frst_rsp_valid_low", 32'(dmi_rsp_valid), 32'd0);
        @(posedge clk_i); #1;
        dmi_rst_n     = 1'b1;
        dmi_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("frst_no_rsp", 32'(dmi_rsp_valid), 32'd0);
        end
        xact(2'd1, 7'd5, 32'h0, 32'h0, 2'd0);
        xact(2'd1, 7'd3, 32'h0, 32'h0, 2'd0);

        // Statistics address
        @(posedge clk_i); #1;
        dmi_rst_n = 1'b0;
        @(posedge clk_i); #1;
        dmi_rst_n = 1'b1;
        xact(2'd0, 7'd0, 32'h0, 32'h0, 2'd0);
        xact(2'd2, 7'd1, 32'h0000A5A5, 32'h0, 2'd0);
        xact(2'd1, 7'd1, 32'h0, 32'h0000A5A5, 2'd0);
        xact(2'd1, 7'd20, 32'h0, 32'h0, 2'd2);
`ifdef DMI_REG_RESPONDER_STATS_EN
        xact(2'd1, 7'h7F, 32'h0, 32'd5, 2'd0);
        xact(2'd2, 7'h7F, 32'h1234, 32'h0, 2'd2);
        xact(2'd1, 7'h7F, 32'h0, 32'd7, 2'd0);
`else
        xact(2'd1, 7'h7F, 32'h0, 32'h0, 2'd2);
        xact(2'd2, 7'h7F, 32'h1234, 32'h0, 2'd2);
        xact(2'd1, 7'h7F, 32'h0, 32'h0, 2'd2);
`endif

        drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
